// File: rtl/mips_controller.sv
// Multicycle MIPS control unit: 15-state Moore FSM producing datapath
// strobes and mux selects, plus the ALU-control decoder.
module mips_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic       memtoreg,
  output logic       iord,
  output logic       regwrite,
  output logic       regdst,
  output logic       pcen,
  output logic [1:0] pcsource,
  output logic [1:0] alusrcb,
  output logic [3:0] irwrite,
  output logic [2:0] alucont
);

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t     state, next_state;
  logic       pcwrite;
  logic       branch;
  logic [1:0] aluop;

  // State register with synchronous reset back to the first fetch cycle.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH1;
    else       state <= next_state;
  end

  // Next-state logic and Moore outputs decoded from the current state.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = FETCH1;
    memread    = 1'b0;
    memwrite   = 1'b0;
    alusrca    = 1'b0;
    memtoreg   = 1'b0;
    iord       = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    pcsource   = 2'b00;
    alusrcb    = 2'b00;
    irwrite    = 4'b0000;
    aluop      = 2'b00;
    case (state)
      FETCH1: begin
        next_state = FETCH2;
        memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b0001;
      end
      FETCH2: begin
        next_state = FETCH3;
        memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b0010;
      end
      FETCH3: begin
        next_state = FETCH4;
        memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b0100;
      end
      FETCH4: begin
        next_state = DECODE;
        memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b1000;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LB, OP_SB: next_state = MEMADR;
          OP_RTYPE:     next_state = RTYPEEX;
          OP_BEQ:       next_state = BEQEX;
          OP_J:         next_state = JEX;
          OP_ADDI:      next_state = ADDIEX;
          default:      next_state = FETCH1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1; alusrcb = 2'b10;
        case (op)
          OP_LB:   next_state = LBRD;
          OP_SB:   next_state = SBWR;
          default: next_state = FETCH1;
        endcase
      end
      LBRD: begin
        next_state = LBWR;
        memread = 1'b1; iord = 1'b1;
      end
      LBWR: begin
        regwrite = 1'b1; memtoreg = 1'b1;
      end
      SBWR: begin
        memwrite = 1'b1; iord = 1'b1;
      end
      RTYPEEX: begin
        next_state = RTYPEWR;
        alusrca = 1'b1; aluop = 2'b10;
      end
      RTYPEWR: begin
        regdst = 1'b1; regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1; aluop = 2'b01; branch = 1'b1; pcsource = 2'b01;
      end
      JEX: begin
        pcwrite = 1'b1; pcsource = 2'b10;
      end
      ADDIEX: begin
        next_state = ADDIWR;
        alusrca = 1'b1; alusrcb = 2'b10;
      end
      ADDIWR: begin
        regwrite = 1'b1;
      end
      default: next_state = FETCH1;
    endcase
  end

  // PC load enable; zero passes straight through during a branch.
  assign pcen = pcwrite | (branch & zero);

  // ALU control: fixed add/sub for address and branch, funct decode for R-type.
  always_comb begin
    alucont = 3'b010;
    case (aluop)
      2'b00: alucont = 3'b010;
      2'b01: alucont = 3'b110;
      default: begin
        case (funct)
          6'b100000: alucont = 3'b010;
          6'b100010: alucont = 3'b110;
          6'b100100: alucont = 3'b000;
          6'b100101: alucont = 3'b001;
          6'b101010: alucont = 3'b111;
          default:   alucont = 3'b101;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_mips_controller.sv
// Scoreboard bench for mips_controller: the stimulus process pushes the
// hand-computed output vector for each cycle, a monitor pops and compares.
module tb_mips_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst, pcen;
  logic [1:0] pcsource, alusrcb;
  logic [3:0] irwrite;
  logic [2:0] alucont;

  mips_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memread(memread), .memwrite(memwrite), .alusrca(alusrca),
    .memtoreg(memtoreg), .iord(iord), .regwrite(regwrite), .regdst(regdst),
    .pcen(pcen), .pcsource(pcsource), .alusrcb(alusrcb),
    .irwrite(irwrite), .alucont(alucont)
  );

  always #5 clk = ~clk;

  // Vector layout: {memread, memwrite, alusrca, memtoreg, iord, regwrite,
  //                 regdst, pcen, pcsource[1:0], alusrcb[1:0], irwrite, alucont}
  localparam logic [18:0] V_F1     = {8'b1000_0001, 2'b00, 2'b01, 4'b0001, 3'b010};
  localparam logic [18:0] V_F2     = {8'b1000_0001, 2'b00, 2'b01, 4'b0010, 3'b010};
  localparam logic [18:0] V_F3     = {8'b1000_0001, 2'b00, 2'b01, 4'b0100, 3'b010};
  localparam logic [18:0] V_F4     = {8'b1000_0001, 2'b00, 2'b01, 4'b1000, 3'b010};
  localparam logic [18:0] V_DEC    = {8'b0000_0000, 2'b00, 2'b11, 4'b0000, 3'b010};
  localparam logic [18:0] V_MEMADR = {8'b0010_0000, 2'b00, 2'b10, 4'b0000, 3'b010};
  localparam logic [18:0] V_LBRD   = {8'b1000_1000, 2'b00, 2'b00, 4'b0000, 3'b010};
  localparam logic [18:0] V_LBWR   = {8'b0001_0100, 2'b00, 2'b00, 4'b0000, 3'b010};
  localparam logic [18:0] V_SBWR   = {8'b0100_1000, 2'b00, 2'b00, 4'b0000, 3'b010};
  localparam logic [18:0] V_RTWR   = {8'b0000_0110, 2'b00, 2'b00, 4'b0000, 3'b010};
  localparam logic [18:0] V_BEQ_Z1 = {8'b0010_0001, 2'b01, 2'b00, 4'b0000, 3'b110};
  localparam logic [18:0] V_BEQ_Z0 = {8'b0010_0000, 2'b01, 2'b00, 4'b0000, 3'b110};
  localparam logic [18:0] V_JEX    = {8'b0000_0001, 2'b10, 2'b00, 4'b0000, 3'b010};
  localparam logic [18:0] V_ADDIEX = {8'b0010_0000, 2'b00, 2'b10, 4'b0000, 3'b010};
  localparam logic [18:0] V_ADDIWR = {8'b0000_0100, 2'b00, 2'b00, 4'b0000, 3'b010};

  typedef struct {
    logic [18:0] vec;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Monitor: the FSM presents a fresh output vector every cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, {memread, memwrite, alusrca, memtoreg, iord, regwrite,
                     regdst, pcen, pcsource, alusrcb, irwrite, alucont}, e.vec);
    end
  end

  // One clock: drive this cycle's inputs, record the expected outputs.
  task automatic cyc(input logic rst, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic [18:0] v, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; op = o; funct = f; zero = z;
    e.vec = v;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // FETCH2..FETCH4 and DECODE with the instruction fields held stable.
  task automatic fetch(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input string tag);
    cyc(1'b0, o, f, z, V_F2,  {tag, "_fetch2"});
    cyc(1'b0, o, f, z, V_F3,  {tag, "_fetch3"});
    cyc(1'b0, o, f, z, V_F4,  {tag, "_fetch4"});
    cyc(1'b0, o, f, z, V_DEC, {tag, "_decode"});
  endtask

  task automatic rtype(input logic [5:0] f, input logic [2:0] ac, input string tag);
    fetch(6'b000000, f, 1'b0, tag);
    cyc(1'b0, 6'b000000, f, 1'b0, {8'b0010_0000, 2'b00, 2'b00, 4'b0000, ac}, {tag, "_rtypeex"});
    cyc(1'b0, 6'b000000, f, 1'b0, V_RTWR, {tag, "_rtypewr"});
    cyc(1'b0, 6'b000000, f, 1'b0, V_F1,   {tag, "_next_fetch1"});
  endtask

  initial begin
    reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;
    @(posedge clk);
    cyc(1'b1, 6'b0, 6'b0, 1'b0, V_F1, "reset_hold");
    cyc(1'b0, 6'b0, 6'b0, 1'b0, V_F1, "reset_fetch1");

    // LB: 8-cycle loop, regwrite/memtoreg only in LBWR.
    fetch(6'b100000, 6'b0, 1'b0, "lb");
    cyc(1'b0, 6'b100000, 6'b0, 1'b0, V_MEMADR, "lb_memadr");
    cyc(1'b0, 6'b100000, 6'b0, 1'b0, V_LBRD,   "lb_lbrd");
    cyc(1'b0, 6'b100000, 6'b0, 1'b0, V_LBWR,   "lb_lbwr");
    cyc(1'b0, 6'b100000, 6'b0, 1'b0, V_F1,     "lb_next_fetch1");

    // SB: 7-cycle loop.
    fetch(6'b101000, 6'b0, 1'b0, "sb");
    cyc(1'b0, 6'b101000, 6'b0, 1'b0, V_MEMADR, "sb_memadr");
    cyc(1'b0, 6'b101000, 6'b0, 1'b0, V_SBWR,   "sb_sbwr");
    cyc(1'b0, 6'b101000, 6'b0, 1'b0, V_F1,     "sb_next_fetch1");

    // R-type with each ALU function, plus an unsupported funct.
    rtype(6'b101010, 3'b111, "rt_slt");
    rtype(6'b100000, 3'b010, "rt_add");
    rtype(6'b100010, 3'b110, "rt_sub");
    rtype(6'b100100, 3'b000, "rt_and");
    rtype(6'b100101, 3'b001, "rt_or");
    rtype(6'b000111, 3'b101, "rt_other");

    // BEQ taken and not taken; zero changes pcen within the same cycle.
    fetch(6'b000100, 6'b0, 1'b1, "beq_t");
    cyc(1'b0, 6'b000100, 6'b0, 1'b1, V_BEQ_Z1, "beq_taken");
    cyc(1'b0, 6'b000100, 6'b0, 1'b0, V_F1,     "beq_t_next_fetch1");
    fetch(6'b000100, 6'b0, 1'b0, "beq_n");
    cyc(1'b0, 6'b000100, 6'b0, 1'b0, V_BEQ_Z0, "beq_not_taken");
    cyc(1'b0, 6'b000100, 6'b0, 1'b0, V_F1,     "beq_n_next_fetch1");

    // J: 6-cycle loop.
    fetch(6'b000010, 6'b0, 1'b0, "j");
    cyc(1'b0, 6'b000010, 6'b0, 1'b0, V_JEX, "j_jex");
    cyc(1'b0, 6'b000010, 6'b0, 1'b0, V_F1,  "j_next_fetch1");

    // ADDI: 7-cycle loop.
    fetch(6'b001000, 6'b0, 1'b0, "addi");
    cyc(1'b0, 6'b001000, 6'b0, 1'b0, V_ADDIEX, "addi_addiex");
    cyc(1'b0, 6'b001000, 6'b0, 1'b0, V_ADDIWR, "addi_addiwr");
    cyc(1'b0, 6'b001000, 6'b0, 1'b0, V_F1,     "addi_next_fetch1");

    // Unknown opcode: DECODE returns straight to FETCH1 (5 cycles).
    fetch(6'b111111, 6'b0, 1'b0, "unk");
    cyc(1'b0, 6'b111111, 6'b0, 1'b0, V_F1, "unk_next_fetch1");

    // Reset asserted during RTYPEWR aborts to FETCH1, no repeated regwrite.
    fetch(6'b000000, 6'b101010, 1'b0, "rst_mid");
    cyc(1'b0, 6'b000000, 6'b101010, 1'b0,
        {8'b0010_0000, 2'b00, 2'b00, 4'b0000, 3'b111}, "rst_mid_rtypeex");
    cyc(1'b1, 6'b000000, 6'b101010, 1'b0, V_RTWR, "rst_mid_rtypewr");
    cyc(1'b0, 6'b000000, 6'b101010, 1'b0, V_F1,   "rst_mid_fetch1");
    cyc(1'b0, 6'b000000, 6'b101010, 1'b0, V_F2,   "rst_mid_fetch2");

    // Let the monitor drain the last expectation, then confirm nothing is left.
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_controller.md
MIPS_CONTROLLER -- requirements
Module: mips_controller

Interface
REQ-001 The block SHALL have no parameters; the encodings below are fixed.
REQ-002 clk  input  1  rising-edge clock for the state register.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  opcode field, instr[31:26], from the instruction register.
REQ-005 funct  input  6  function field, instr[5:0], for R-type.
REQ-006 zero  input  1  ALU result-equals-zero flag.
REQ-007 memread, memwrite  output  1 each  memory read and write strobes.
REQ-008 alusrca, memtoreg, iord, regwrite, regdst  output  1 each  datapath mux selects and enables.
REQ-009 pcen  output  1  PC load enable, equal to pcwrite OR (branch AND zero).
REQ-010 pcsource, alusrcb  output  2 each  PC-source and ALU-B mux selects.
REQ-011 irwrite  output  4  byte-lane enables of the instruction register.
REQ-012 alucont  output  3  ALU operation code.

Function
REQ-013 The block SHALL be a Moore FSM with 15 states:
- FETCH1, FETCH2, FETCH3, FETCH4, DECODE
- MEMADR, LBRD, LBWR, SBWR
- RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR

REQ-014 Opcodes SHALL be decoded as:
- LB = 100000, SB = 101000
- RTYPE = 000000, BEQ = 000100
- J = 000010, ADDI = 001000

REQ-015 Transitions SHALL occur one per clk edge:
- FETCH1 -> FETCH2 -> FETCH3 -> FETCH4 -> DECODE.
- DECODE -> MEMADR for LB or SB; RTYPEEX for RTYPE; BEQEX for BEQ; JEX for J; ADDIEX for ADDI; FETCH1 for any other opcode.
- MEMADR -> LBRD for LB, SBWR for SB, FETCH1 otherwise.
- LBRD -> LBWR -> FETCH1; SBWR -> FETCH1.
- RTYPEEX -> RTYPEWR -> FETCH1.
- BEQEX -> FETCH1; JEX -> FETCH1.
- ADDIEX -> ADDIWR -> FETCH1.

REQ-016 Outputs SHALL depend on the current state only; every output not listed below is 0.
- FETCHn: memread = 1, alusrcb = 01, pcwrite = 1, irwrite = one-hot lane n-1 (0001, 0010, 0100, 1000).
- DECODE: alusrcb = 11.
- MEMADR: alusrca = 1, alusrcb = 10.
- LBRD: memread = 1, iord = 1.
- LBWR: regwrite = 1, memtoreg = 1.
- SBWR: memwrite = 1, iord = 1.
- RTYPEEX: alusrca = 1, aluop = 10.
- RTYPEWR: regdst = 1, regwrite = 1.
- BEQEX: alusrca = 1, aluop = 01, branch = 1, pcsource = 01.
- JEX: pcwrite = 1, pcsource = 10.
- ADDIEX: alusrca = 1, alusrcb = 10.
- ADDIWR: regwrite = 1.

REQ-017 pcwrite, branch and aluop[1:0] SHALL be internal signals only.

REQ-018 alucont SHALL be combinational from aluop and funct:
- aluop = 00 -> 010 (add).
- aluop = 01 -> 110 (subtract).
- aluop = 1x with funct 100000 -> 010 (add); 100010 -> 110 (sub); 100100 -> 000 (and); 100101 -> 001 (or); 101010 -> 111 (slt).
- Any other funct -> 101.

REQ-019 pcen SHALL follow zero combinationally in BEQEX, with no added latency.

REQ-020 Instruction latencies, counted from FETCH1 entry to the next FETCH1 entry, SHALL be:
- LB 8 cycles; SB, R-type and ADDI 7 cycles.
- BEQ and J 6 cycles.
- Unknown opcode 5 cycles.

REQ-021 op and funct SHALL be sampled each cycle with no internal latching; the datapath holds them stable through the instruction register.

Reset
REQ-022 While reset = 1 at a clk edge, the state SHALL become FETCH1, overriding every transition, including one taken mid-instruction.
REQ-023 Output values after reset (FETCH1 values) SHALL be:
- memread = 1, pcen = 1, irwrite = 0001, alusrcb = 01.
- alucont = 010.
- All other outputs 0.

REQ-024 Encodings of unused states SHALL transition to FETCH1 and drive all outputs to 0.

Verification
REQ-025 Reset, then op = 100000 -> states FETCH1..4, DECODE, MEMADR, LBRD, LBWR, then FETCH1; regwrite = 1 and memtoreg = 1 only in LBWR.
REQ-026 op = 000000, funct = 101010 -> alucont = 111 in RTYPEEX; regdst = 1 and regwrite = 1 in RTYPEWR; 7-cycle loop.
REQ-027 op = 000100 in BEQEX with zero = 1 -> pcen = 1 and pcsource = 01; repeat with zero = 0 -> pcen = 0.
REQ-028 op = 000010 -> pcen = 1 and pcsource = 10 in JEX; op = 111111 -> DECODE returns to FETCH1.
REQ-029 Assert reset during RTYPEWR -> next state is FETCH1 with irwrite = 0001; regwrite is not asserted again.
